// File: rtl/instr_mem_loadable_if.sv
// Load and fetch bus of the loadable instruction memory.
//   master: drives load beats and fetch requests (loader / PC side).
//   slave : the instruction memory.
// Load port : load_start, load_valid, load_last, load_data -> load_ready, load_done, prog_len
// Fetch port: fetch_en, stall, flush, pc -> instr, instr_valid, addr_fault
interface instr_mem_loadable_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);

  logic              load_start;
  logic              load_valid;
  logic              load_last;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   prog_len;

  logic              fetch_en;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_fault;

  modport master (
    output load_start, load_valid, load_last, load_data,
    output fetch_en, stall, flush, pc,
    input  load_ready, load_done, prog_len,
    input  instr, instr_valid, addr_fault
  );

  modport slave (
    input  load_start, load_valid, load_last, load_data,
    input  fetch_en, stall, flush, pc,
    output load_ready, load_done, prog_len,
    output instr, instr_valid, addr_fault
  );

endinterface

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction store with a 1-cycle synchronous fetch port.
// A program is streamed in through the valid/ready load port starting at word 0;
// once loaded, fetches return mem[pc], or NOP_WORD with addr_fault for pc >= prog_len.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   bus      instr_mem_loadable_if.slave (load port + fetch port)
module instr_mem_loadable #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DEPTH    = 1000,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0400001F)
) (
  input logic                 clk,
  input logic                 rst,
  instr_mem_loadable_if.slave bus
);

  localparam int unsigned PLEN_W = ADDR_W + 1;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PLEN_W-1:0]   prog_len_q, prog_len_d;
  logic                load_done_q, load_done_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   instr_q;
  logic                instr_valid_q;
  logic                addr_fault_q;
  logic                pc_in_range;

  // Load FSM: next state, write pointer, program length and write enable
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len_q;
    load_done_d = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (bus.load_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          // Last beat is either flagged or the one that fills the array
          if (bus.load_last || (wr_ptr_q == ADDR_W'(DEPTH - 1))) begin
            state_d     = READY;
            prog_len_d  = PLEN_W'(wr_ptr_q) + PLEN_W'(1);
            load_done_d = 1'b1;
          end
        end
      end
      READY: begin
        // Reload invalidates the old program at once
        if (bus.load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Load FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= '0;
      prog_len_q  <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_len_q  <= prog_len_d;
      load_done_q <= load_done_d;
    end
  end

  // Single write port; contents survive reset (unreachable while prog_len is 0)
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[MEM_AW'(wr_ptr_q)] <= bus.load_data;
    end
  end

  // Unsigned compare; prog_len never exceeds DEPTH so pc >= DEPTH always faults
  assign pc_in_range = {1'b0, bus.pc} < prog_len_q;

  // Fetch port: registered read with flush > stall > fetch priority
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
    end else if ((state_q != READY) || bus.flush) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
    end else if (bus.stall) begin
      instr_q       <= instr_q;
      instr_valid_q <= instr_valid_q;
      addr_fault_q  <= addr_fault_q;
    end else if (bus.fetch_en) begin
      instr_valid_q <= 1'b1;
      if (pc_in_range) begin
        instr_q      <= mem[MEM_AW'(bus.pc)];
        addr_fault_q <= 1'b0;
      end else begin
        instr_q      <= NOP_WORD;
        addr_fault_q <= 1'b1;
      end
    end else begin
      instr_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
    end
  end

  // Beats are accepted in every LOAD cycle, so ready follows the state directly
  assign bus.load_ready  = (state_q == LOAD);
  assign bus.load_done   = load_done_q;
  assign bus.prog_len    = prog_len_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.addr_fault  = addr_fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: directed load/fetch vectors,
// randomized reloads and fetch traffic against a behavioural model, reset
// mid-load, and a DEPTH=4 instance for the array-full boundary.
module tb_instr_mem_loadable;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1000;
  localparam logic [31:0] NOP   = 32'h0400001F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_loadable_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  instr_mem_loadable_if #(.DATA_W(DW), .ADDR_W(AW)) bus4 ();

  instr_mem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  instr_mem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .NOP_WORD(NOP)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the loaded program and fetch outputs (READY state)
  logic [31:0] mm [1024];
  int          plen;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_fault;

  typedef struct {
    logic        fe;
    logic        st;
    logic        fl;
    logic [9:0]  pc;
    logic [31:0] ei;
    logic        ev;
    logic        ef;
  } fvec_t;

  typedef struct {
    logic        v;
    logic        l;
    logic [31:0] d;
  } beat_t;

  fvec_t tab [16];
  beat_t beats [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.load_start = 0; bus.load_valid = 0; bus.load_last = 0; bus.load_data = '0;
    bus.fetch_en = 0; bus.stall = 0; bus.flush = 0; bus.pc = '0;
  endtask

  task automatic idle4();
    bus4.load_start = 0; bus4.load_valid = 0; bus4.load_last = 0; bus4.load_data = '0;
    bus4.fetch_en = 0; bus4.stall = 0; bus4.flush = 0; bus4.pc = '0;
  endtask

  task automatic model_fetch(input logic fe, input logic st, input logic fl, input logic [9:0] p);
    if (fl) begin
      m_instr = NOP; m_valid = 0; m_fault = 0;
    end else if (st) begin
      // outputs hold
    end else if (fe) begin
      m_valid = 1;
      if (int'(p) < plen) begin
        m_instr = mm[p]; m_fault = 0;
      end else begin
        m_instr = NOP; m_fault = 1;
      end
    end else begin
      m_valid = 0; m_fault = 0;
    end
  endtask

  task automatic check_fetch(input string tag);
    chk({tag, " instr"}, 64'(bus.instr), 64'(m_instr));
    chk({tag, " instr_valid"}, 64'(bus.instr_valid), 64'(m_valid));
    chk({tag, " addr_fault"}, 64'(bus.addr_fault), 64'(m_fault));
  endtask

  task automatic rand_fetch(input int n);
    logic fe, st, fl;
    logic [9:0] p;
    for (int i = 0; i < n; i++) begin
      fe = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 9) == 0);
      p  = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, plen + 1));
      bus.fetch_en = fe; bus.stall = st; bus.flush = fl; bus.pc = p;
      step();
      model_fetch(fe, st, fl, p);
      check_fetch("rand fetch");
    end
    idle();
  endtask

  task automatic rand_load(input int n);
    logic [31:0] d;
    idle();
    bus.load_start = 1;
    step();
    bus.load_start = 0;
    chk("reload prog_len cleared", 64'(bus.prog_len), 64'd0);
    chk("reload load_ready", 64'(bus.load_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.load_valid = 0;
        step();
        chk("rand load gap load_done", 64'(bus.load_done), 64'd0);
      end
      d = $urandom;
      mm[i] = d;
      bus.load_valid = 1; bus.load_last = (i == n - 1); bus.load_data = d;
      step();
      bus.load_valid = 0; bus.load_last = 0;
      chk("rand load instr_valid", 64'(bus.instr_valid), 64'd0);
      chk("rand load load_done", 64'(bus.load_done), (i == n - 1) ? 64'd1 : 64'd0);
      if (i == n - 1) chk("rand load prog_len", 64'(bus.prog_len), 64'(n));
    end
    plen = n; m_instr = NOP; m_valid = 0; m_fault = 0;
    step();
    chk("rand load done pulse end", 64'(bus.load_done), 64'd0);
    check_fetch("after rand load");
  endtask

  initial begin
    beats[0] = '{1'b1, 1'b0, 32'h08011000};
    beats[1] = '{1'b0, 1'b0, 32'h0};
    beats[2] = '{1'b1, 1'b0, 32'h08021001};
    beats[3] = '{1'b1, 1'b1, 32'h08031002};

    tab[0]  = '{1'b1, 1'b0, 1'b0, 10'd0,    32'h08011000, 1'b1, 1'b0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 10'd1,    32'h08021001, 1'b1, 1'b0};
    tab[2]  = '{1'b1, 1'b0, 1'b0, 10'd2,    32'h08031002, 1'b1, 1'b0};
    tab[3]  = '{1'b1, 1'b0, 1'b0, 10'd3,    NOP,          1'b1, 1'b1};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 10'd999,  NOP,          1'b1, 1'b1};
    tab[5]  = '{1'b1, 1'b0, 1'b0, 10'd1,    32'h08021001, 1'b1, 1'b0};
    tab[6]  = '{1'b1, 1'b0, 1'b0, 10'd0,    32'h08011000, 1'b1, 1'b0};
    tab[7]  = '{1'b1, 1'b1, 1'b0, 10'd2,    32'h08011000, 1'b1, 1'b0};
    tab[8]  = '{1'b1, 1'b1, 1'b0, 10'd3,    32'h08011000, 1'b1, 1'b0};
    tab[9]  = '{1'b1, 1'b1, 1'b0, 10'd1,    32'h08011000, 1'b1, 1'b0};
    tab[10] = '{1'b1, 1'b1, 1'b1, 10'd1,    NOP,          1'b0, 1'b0};
    tab[11] = '{1'b1, 1'b0, 1'b0, 10'd2,    32'h08031002, 1'b1, 1'b0};
    tab[12] = '{1'b0, 1'b0, 1'b0, 10'd0,    32'h08031002, 1'b0, 1'b0};
    tab[13] = '{1'b0, 1'b1, 1'b0, 10'd3,    32'h08031002, 1'b0, 1'b0};
    tab[14] = '{1'b1, 1'b0, 1'b0, 10'd1023, NOP,          1'b1, 1'b1};
    tab[15] = '{1'b0, 1'b1, 1'b0, 10'd0,    NOP,          1'b1, 1'b1};

    // Reset state
    rst = 1; idle(); idle4();
    step();
    chk("reset instr", 64'(bus.instr), 64'(NOP));
    chk("reset instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("reset addr_fault", 64'(bus.addr_fault), 64'd0);
    chk("reset load_ready", 64'(bus.load_ready), 64'd0);
    chk("reset load_done", 64'(bus.load_done), 64'd0);
    chk("reset prog_len", 64'(bus.prog_len), 64'd0);
    rst = 0;
    bus.fetch_en = 1; bus.pc = '0;
    step();
    chk("empty fetch instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("empty fetch instr", 64'(bus.instr), 64'(NOP));

    // Three-word load with a gap
    idle();
    bus.load_start = 1;
    step();
    bus.load_start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("load load_ready", 64'(bus.load_ready), 64'd1);
      bus.load_valid = beats[i].v; bus.load_last = beats[i].l; bus.load_data = beats[i].d;
      step();
      chk("load load_done", 64'(bus.load_done), (i == 3) ? 64'd1 : 64'd0);
    end
    idle();
    chk("load prog_len", 64'(bus.prog_len), 64'd3);
    chk("load ready after last", 64'(bus.load_ready), 64'd0);
    step();
    chk("load_done single pulse", 64'(bus.load_done), 64'd0);
    mm[0] = 32'h08011000; mm[1] = 32'h08021001; mm[2] = 32'h08031002; plen = 3;

    // Directed fetch vectors
    for (int i = 0; i < 16; i++) begin
      bus.fetch_en = tab[i].fe; bus.stall = tab[i].st; bus.flush = tab[i].fl; bus.pc = tab[i].pc;
      step();
      chk($sformatf("vec%0d instr", i), 64'(bus.instr), 64'(tab[i].ei));
      chk($sformatf("vec%0d instr_valid", i), 64'(bus.instr_valid), 64'(tab[i].ev));
      chk($sformatf("vec%0d addr_fault", i), 64'(bus.addr_fault), 64'(tab[i].ef));
    end
    idle();
    m_instr = NOP; m_valid = 1; m_fault = 1;

    // Random fetch traffic, then random reloads
    rand_fetch(150);
    for (int r = 0; r < 4; r++) begin
      rand_load(int'($urandom_range(1, 12)));
      rand_fetch(100);
    end

    // Reset in the middle of a load
    idle();
    bus.load_start = 1;
    step();
    bus.load_start = 0;
    bus.load_valid = 1; bus.load_data = 32'h11111111;
    step();
    bus.load_data = 32'h22222222;
    step();
    bus.load_valid = 0;
    rst = 1;
    step();
    rst = 0;
    chk("midload rst prog_len", 64'(bus.prog_len), 64'd0);
    chk("midload rst load_ready", 64'(bus.load_ready), 64'd0);
    chk("midload rst instr_valid", 64'(bus.instr_valid), 64'd0);
    bus.fetch_en = 1; bus.pc = '0;
    step();
    chk("post rst fetch instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("post rst load_ready", 64'(bus.load_ready), 64'd0);
    idle();
    bus.load_start = 1;
    step();
    bus.load_start = 0;
    bus.load_valid = 1; bus.load_last = 1; bus.load_data = 32'hAAAA5555;
    step();
    idle();
    chk("one-word load_done", 64'(bus.load_done), 64'd1);
    chk("one-word prog_len", 64'(bus.prog_len), 64'd1);
    bus.fetch_en = 1; bus.pc = 10'd0;
    step();
    chk("one-word pc0 instr", 64'(bus.instr), 64'h00000000AAAA5555);
    chk("one-word pc0 valid", 64'(bus.instr_valid), 64'd1);
    chk("one-word pc0 fault", 64'(bus.addr_fault), 64'd0);
    bus.pc = 10'd1;
    step();
    chk("one-word pc1 instr", 64'(bus.instr), 64'(NOP));
    chk("one-word pc1 valid", 64'(bus.instr_valid), 64'd1);
    chk("one-word pc1 fault", 64'(bus.addr_fault), 64'd1);
    idle();

    // DEPTH=4 instance: array fills without load_last, extra beats ignored
    bus4.load_start = 1;
    step();
    bus4.load_start = 0;
    for (int b = 0; b < 6; b++) begin
      chk($sformatf("d4 beat%0d load_ready", b), 64'(bus4.load_ready), (b < 4) ? 64'd1 : 64'd0);
      bus4.load_valid = 1; bus4.load_data = 32'h40000000 + 32'(b);
      bus4.load_start = (b == 1);
      step();
      chk($sformatf("d4 beat%0d load_done", b), 64'(bus4.load_done), (b == 3) ? 64'd1 : 64'd0);
      if (b >= 3) chk($sformatf("d4 beat%0d prog_len", b), 64'(bus4.prog_len), 64'd4);
    end
    idle4();
    step();
    for (int p = 0; p < 5; p++) begin
      bus4.fetch_en = 1; bus4.pc = 10'(p);
      step();
      chk($sformatf("d4 pc%0d instr", p), 64'(bus4.instr), (p < 4) ? 64'(32'h40000000 + 32'(p)) : 64'(NOP));
      chk($sformatf("d4 pc%0d valid", p), 64'(bus4.instr_valid), 64'd1);
      chk($sformatf("d4 pc%0d fault", p), 64'(bus4.addr_fault), (p < 4) ? 64'd0 : 64'd1);
    end
    idle4();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised successor to the fixed-program instruction memory: a synchronous-read instruction store that is loaded at run time through a valid/ready load port instead of a hard-coded initial block.
- Serves the fetch stage with 1-cycle read latency and supports stall and flush.
- Returns NOP and raises a fault for any PC beyond the loaded program.
- Sits between the PC register and the decode stage.

Parameters:
- DATA_W, 32, instruction word width.
- ADDR_W, 10, PC/address width.
- DEPTH, 1000, number of instruction words; DEPTH <= 2**ADDR_W.
- NOP_WORD, 32'h0400001F, word returned on fault, flush, reset and when not ready.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- load_start  in  1  begin (re)load at address 0.
- load_valid  in  1  load_data valid.
- load_last  in  1  current beat is the final program word.
- load_data  in  DATA_W  program word.
- load_ready  out  1  block accepts a load beat this cycle.
- load_done  out  1  one-cycle pulse, load completed.
- prog_len  out  ADDR_W+1  number of words loaded.
- fetch_en  in  1  request fetch at pc.
- stall  in  1  hold fetch outputs.
- flush  in  1  squash fetch output.
- pc  in  ADDR_W  fetch address (word index).
- instr  out  DATA_W  fetched instruction.
- instr_valid  out  1  instr is valid.
- addr_fault  out  1  fetched pc was >= prog_len.

Behaviour:
- Reset (any state, including mid-load):
  - state=EMPTY, wr_ptr=0, prog_len=0.
  - instr=NOP_WORD, instr_valid=0, addr_fault=0, load_ready=0, load_done=0.
  - Array contents are not cleared; any partially loaded words are unreachable because prog_len=0.
- FSM states EMPTY, LOAD, READY:
  - EMPTY: load_start -> LOAD with wr_ptr=0.
  - LOAD: load_ready=1 (combinational from state). A beat is accepted when load_valid & load_ready: mem[wr_ptr] <= load_data, wr_ptr++.
    - If the accepted beat has load_last=1 or wr_ptr==DEPTH-1: go to READY, prog_len <= wr_ptr+1, load_done=1 the following cycle only.
    - Gaps (load_valid=0) are allowed. load_start while in LOAD is ignored.
  - READY: load_start -> LOAD, wr_ptr=0, prog_len <= 0 (prior program invalidated immediately).
- Fetch, evaluated on the rising edge in priority order rst > flush > stall > fetch:
  - state != READY: instr<=NOP_WORD, instr_valid<=0, addr_fault<=0.
  - flush=1: instr<=NOP_WORD, instr_valid<=0, addr_fault<=0. Flush overrides stall.
  - stall=1: instr, instr_valid and addr_fault hold their values.
  - fetch_en=1, pc<prog_len: instr<=mem[pc], instr_valid<=1, addr_fault<=0 (1-cycle latency).
  - fetch_en=1, pc>=prog_len: instr<=NOP_WORD, instr_valid<=1, addr_fault<=1.
  - fetch_en=0: instr_valid<=0, addr_fault<=0, instr holds.
- Comparison pc<prog_len is unsigned, zero-extended to ADDR_W+1 bits. pc values >= DEPTH always fault.
- Load and fetch are never concurrent: fetch is inactive outside READY, so there is no read-during-write hazard.
- Array must infer block RAM: single write port, registered read.

Test Plan:
- Reset with all inputs 0 -> instr=0x0400001F, instr_valid=0, addr_fault=0, load_ready=0, prog_len=0 on the next cycle; fetch_en=1 pc=0 keeps instr_valid=0.
- load_start, then beats 0x08011000, 0x08021001 (load_valid gap between them), 0x08031002 with load_last -> load_ready=1 during LOAD, load_done pulses exactly one cycle, prog_len=3; fetch pc=0,1,2 on consecutive cycles -> the same words, one cycle later each, instr_valid=1.
- After the load above, fetch pc=3 and pc=999 -> instr=0x0400001F, instr_valid=1, addr_fault=1; then fetch pc=1 -> 0x08021001, addr_fault=0.
- Fetch pc=0, then stall=1 for 3 cycles while pc changes -> instr=0x08011000 held with instr_valid=1; assert flush with stall still high -> instr=NOP_WORD, instr_valid=0 on the next edge.
- DEPTH=4 override, 6 beats with no load_last -> first 4 accepted, READY after beat 4, load_ready=0, beats 5-6 ignored, prog_len=4, mem[0..3] equal beats 1-4.
- rst after 2 accepted load beats -> EMPTY, prog_len=0, fetch inactive; fresh 1-word load of 0xAAAA5555 -> fetch pc=0 returns 0xAAAA5555, pc=1 faults.
